// File: rtl/seq_detector_if.sv
// seq_detector_if: stream, configuration and status signals of the serial
// sequence detector, bundled so the detector and its driver share one port.
//
//   valid_i     stream bit qualifier
//   in_i        serial data bit
//   clr_i       clear history, fill and match counter
//   cfg_we_i    configuration write strobe
//   pattern_i   new pattern (bit len-1 = first-received, bit 0 = last)
//   len_i       new pattern length (1..PAT_W accepted)
//   overlap_i   new mode: 1 = overlapping, 0 = non-overlapping
//   match_o     one-cycle pulse per detected match
//   match_cnt_o saturating match count
//   cfg_err_o   one-cycle pulse on a rejected configuration write
interface seq_detector_if #(
  parameter int PAT_W   = 8,
  parameter int COUNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic               valid_i;
  logic               in_i;
  logic               clr_i;
  logic               cfg_we_i;
  logic [PAT_W-1:0]   pattern_i;
  logic [LEN_W-1:0]   len_i;
  logic               overlap_i;
  logic               match_o;
  logic [COUNT_W-1:0] match_cnt_o;
  logic               cfg_err_o;

  // master drives the stream and configuration, slave is the detector
  modport master (
    output valid_i, in_i, clr_i, cfg_we_i, pattern_i, len_i, overlap_i,
    input  match_o, match_cnt_o, cfg_err_o
  );

  modport slave (
    input  valid_i, in_i, clr_i, cfg_we_i, pattern_i, len_i, overlap_i,
    output match_o, match_cnt_o, cfg_err_o
  );
endinterface

// File: rtl/seq_detector.sv
// seq_detector: flags every occurrence of a run-time programmable bit
// pattern (length 1..PAT_W) in a qualified serial stream, with selectable
// overlapping / non-overlapping matching and a saturating match counter.
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    seq_detector_if.slave (stream in, config in, status out)
// All outputs are registered; a match whose final bit is sampled at edge N
// is visible on match_o / match_cnt_o during cycle N+1.
module seq_detector #(
  parameter int               PAT_W       = 8,
  parameter int               COUNT_W     = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = 8'h0B,
  parameter int               RST_LEN     = 4,
  parameter logic             RST_OVERLAP = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  seq_detector_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]   hist_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [PAT_W-1:0]   cfg_pat_reg;
  logic [LEN_W-1:0]   cfg_len_reg;
  logic               cfg_ovl_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               match_reg;
  logic               cfg_err_reg;

  logic [PAT_W-1:0]   hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [PAT_W-1:0]   len_mask;
  logic               len_ok;
  logic               match_hit;

  // Compare mask: only the low cfg_len bits of history/pattern take part.
  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign len_mask[gi] = (cfg_len_reg > LEN_W'(gi));
    end
  endgenerate

  assign hist_next = {hist_reg[PAT_W-2:0], bus.in_i};
  assign fill_next = (fill_reg == LEN_W'(PAT_W)) ? fill_reg : fill_reg + 1'b1;
  assign len_ok    = (bus.len_i != '0) && (bus.len_i <= LEN_W'(PAT_W));

  // fill guards against stale history (zeros after clear) forming a match.
  assign match_hit = (fill_next >= cfg_len_reg) &&
                     (((hist_next ^ cfg_pat_reg) & len_mask) == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      cfg_pat_reg <= RST_PATTERN;
      cfg_len_reg <= LEN_W'(RST_LEN);
      cfg_ovl_reg <= RST_OVERLAP;
      count_reg   <= '0;
      match_reg   <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      match_reg   <= 1'b0;
      cfg_err_reg <= 1'b0;
      if (bus.clr_i) begin
        hist_reg  <= '0;
        fill_reg  <= '0;
        count_reg <= '0;
      end else if (bus.cfg_we_i && len_ok) begin
        // New config starts from an empty history; the count survives.
        cfg_pat_reg <= bus.pattern_i;
        cfg_len_reg <= bus.len_i;
        cfg_ovl_reg <= bus.overlap_i;
        hist_reg    <= '0;
        fill_reg    <= '0;
      end else begin
        // A rejected config write does not consume the stream bit.
        if (bus.cfg_we_i) begin
          cfg_err_reg <= 1'b1;
        end
        if (bus.valid_i) begin
          hist_reg <= hist_next;
          if (match_hit) begin
            match_reg <= 1'b1;
            if (count_reg != '1) begin
              count_reg <= count_reg + 1'b1;
            end
            // Non-overlap: matched bits may not seed the next match.
            fill_reg <= cfg_ovl_reg ? fill_next : '0;
          end else begin
            fill_reg <= fill_next;
          end
        end
      end
    end
  end

  assign bus.match_o     = match_reg;
  assign bus.match_cnt_o = count_reg;
  assign bus.cfg_err_o   = cfg_err_reg;
endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial sequence detector. It watches a 1-bit qualified input stream and flags every occurrence of a run-time programmable bit pattern of length 1..PAT_W. Overlapping or non-overlapping matching is selectable, and matches are counted in a saturating counter. It generalises the fixed four-state serial detector FSM for protocol/preamble detection in front of downstream framing logic.

## Interface
- PAT_W, 8: maximum pattern length in bits (>=2).
- COUNT_W, 8: match counter width.
- RST_PATTERN, 8'h0B: pattern loaded at reset (low RST_LEN bits used).
- RST_LEN, 4: pattern length loaded at reset (1..PAT_W).
- RST_OVERLAP, 1: overlap mode loaded at reset.

- clk_i  in  1  single clock, all logic rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  in_i carries a stream bit this cycle.
- in_i  in  1  serial data bit.
- clr_i  in  1  clear history, fill and match counter.
- cfg_we_i  in  1  load configuration from pattern_i/len_i/overlap_i.
- pattern_i  in  PAT_W  new pattern; bit len-1 = first-received bit, bit 0 = last.
- len_i  in  $clog2(PAT_W+1)  new pattern length.
- overlap_i  in  1  new mode: 1 = overlapping, 0 = non-overlapping.
- match_o  out  1  one-cycle pulse per detected match.
- match_cnt_o  out  COUNT_W  saturating match count.
- cfg_err_o  out  1  one-cycle pulse on rejected configuration write.

## Operation
- State: hist (PAT_W-bit shift register, newest bit at bit 0), fill (accepted bits since last clear, saturating at PAT_W), cfg_pat, cfg_len, cfg_ovl, count.
- On valid_i=1: hist <= {hist[PAT_W-2:0], in_i}; fill <= min(fill+1, PAT_W).
- Match condition, evaluated on the updated history: (fill_next >= cfg_len) and (hist_next[cfg_len-1:0] == cfg_pat[cfg_len-1:0]).
- On match: match_o <= 1; count increments, holding at 2^COUNT_W-1 (no wrap).
- Overlap mode: fill is unchanged by a match, so matched bits may start the next match.
- Non-overlap mode: fill <= 0 on a match. The next match needs cfg_len fresh bits.
- valid_i=0: hist, fill and count hold; match_o <= 0.
- Priority, highest first: rst_i, clr_i, cfg_we_i, valid_i.
  - clr_i: hist, fill and count <= 0. A same-cycle valid_i bit is discarded and no match is reported.
  - cfg_we_i with 1 <= len_i <= PAT_W: cfg registers load, hist and fill <= 0, count kept. A same-cycle valid_i bit is discarded.
  - cfg_we_i with len_i = 0 or len_i > PAT_W: config unchanged, hist/fill unchanged, cfg_err_o <= 1 for one cycle. A same-cycle valid_i bit is processed normally.
- Pattern bits above cfg_len-1 are ignored.

## Timing
- Reset values: match_o=0, match_cnt_o=0, cfg_err_o=0, hist=0, fill=0, cfg_pat=RST_PATTERN, cfg_len=RST_LEN, cfg_ovl=RST_OVERLAP.
- All outputs are registered.
- Latency: final pattern bit sampled at edge N gives match_o=1 and the updated match_cnt_o during cycle N+1.
- A match needs at least cfg_len valid bits since the last reset, clear or config load. Stale history never matches.
- Back-to-back matches in overlap mode with cfg_len=1 give match_o high on consecutive cycles.
- Reset mid-pattern discards the partial history. A match whose last bit lands on the reset edge is not reported.
- The new configuration applies from the first valid_i bit after the cfg_we_i cycle.

## Test plan
- Reset, then valid bits 1,0,1,1 on consecutive cycles: match_o pulses one cycle after the 4th bit, match_cnt_o=1, and no pulse after bits 1-3.
- Overlap mode:
  - Config pattern 3'b101, len 3, overlap 1, stream 1,0,1,0,1: matches after bits 3 and 5, count=2.
  - Same stream with overlap 0: a single match after bit 3, count=1.
- Gaps: stream 1, idle, 0, 1, idle x3, 1 with the reset pattern: exactly one match, after the last bit. Nothing changes during idle cycles.
- COUNT_W=2, pattern len 1 value 1, overlap 1, six consecutive 1s: six match pulses, and match_cnt_o saturates at 3.
- Config errors and clear:
  - cfg_we_i with len_i=0, and with len_i=9: cfg_err_o pulses each time, and the old pattern still matches afterwards.
  - Bits 1,0,1, then clr_i (with valid_i=1, in_i=1 in the same cycle), then 1: no match, count=0.
- Assert rst_i on the cycle the 4th reset-pattern bit arrives: no match_o pulse. Then 1,0,1,1 again gives a match with count=1.
